mpu9250_init_seq: RTL
=====================

// Module: mpu9250_init_seq
// PURPOSE
//  Upstream command sequencer for the I2C byte-write engine. On start, walks a fixed
//  6-entry MPU9250 register/data table and issues one single-register write per entry
//  through the engine's GO/BUSY/OK/ACK_err handshake. Inserts settle gaps between
//  writes, retries NACKed writes and reports done/fail to the top-level controller.
// PARAMETERS
//  DEV_ADDR    7'h68  7-bit I2C slave address driven on wr_addr for every write
//  MAX_RETRY   3      attempts per entry (first try included) before fail
//  GAP_CYCLES  16     SDA_CLK idle cycles between consecutive writes, min 1
//  RESET_GAP   2000   gap after entry 0 (device reset), replaces GAP_CYCLES
//  TIMEOUT     512    SDA_CLK cycles allowed from wr_go to wr_ok before fail
// PORTS
//  SDA_CLK     in   1  clock; shared with the write engine's SDA-side clock
//  reset_n     in   1  asynchronous, active-low reset
//  start       in   1  level/pulse; sampled only in IDLE, DONE or FAIL
//  wr_busy     in   1  engine BUSY; low only while the engine is idle
//  wr_ok       in   1  engine OK; one-cycle pulse at end of each transfer
//  wr_ack_err  in   1  engine ACK_err; valid in the cycle wr_ok=1
//  wr_go       out  1  one-cycle write request to engine
//  wr_addr     out  7  slave address, constant DEV_ADDR
//  wr_reg_addr out  8  register address of current entry
//  wr_data     out  8  data byte of current entry
//  busy        out  1  high from accepted start until DONE/FAIL
//  done        out  1  sticky: all 6 entries written with ACK
//  fail        out  1  sticky: retry limit or timeout hit
//  cmd_idx     out  3  index of current/failing entry (0..5)
// BEHAVIOUR
//  Reset: state=IDLE; wr_go=0, busy=0, done=0, fail=0, cmd_idx=0, retry/gap/timeout
//   counters=0; wr_reg_addr=8'h00, wr_data=8'h00; wr_addr=DEV_ADDR always.
//  Table (idx: reg,data): 0:6B,80 1:6B,01 2:6C,00 3:1A,03 4:1B,18 5:1C,08.
//  wr_reg_addr/wr_data are registered from table[cmd_idx] in LOAD; held stable
//   until the next LOAD (engine latches them on the GO edge).
//  FSM:
//   IDLE: start=1 -> LOAD, busy<=1, cmd_idx<=0, retry<=0.
//   LOAD: drive table outputs -> ISSUE.
//   ISSUE: wait wr_busy=0; then wr_go<=1 for exactly one cycle, timeout<=0 -> WAIT_OK.
//   WAIT_OK: ignore wr_busy; count timeout each cycle.
//    wr_ok=1 & wr_ack_err=0 -> retry<=0, WAIT_IDLE.
//    wr_ok=1 & wr_ack_err=1 -> retry+1; if retry+1==MAX_RETRY -> FAIL else WAIT_IDLE
//     with same cmd_idx (reissue).
//    timeout==TIMEOUT-1 without wr_ok -> FAIL. wr_ok in the expiry cycle wins.
//   WAIT_IDLE: wait wr_busy=0 -> GAP, gap<=0.
//   GAP: count to RESET_GAP-1 (cmd_idx 0, acked) else GAP_CYCLES-1; then:
//    reissue pending -> ISSUE; cmd_idx==5 acked -> DONE; else cmd_idx+1 -> LOAD.
//   DONE: busy<=0, done<=1. FAIL: busy<=0, fail<=1, cmd_idx frozen.
//   DONE/FAIL + start=1 -> clear done/fail, restart as from IDLE.
//  start while busy=1 ignored. wr_go never asserted twice per transfer; never while
//   wr_busy=1. Latency start->first wr_go: 3 cycles if engine idle.
//  Reset mid-operation: immediate return to reset values; engine reset is shared.
//  Counters sized to hold max(RESET_GAP,TIMEOUT); retry width clog2(MAX_RETRY+1).
// TESTING
//  Engine model ACKs all: start pulse -> 6 wr_go pulses, reg/data 6B80,6B01,6C00,
//   1A03,1B18,1C08; gap after idx0 >= 2000 cycles; done=1, busy=0, fail=0.
//  Model NACKs idx 3 once: idx 3 issued twice with 1A/03, then idx 4,5; done=1.
//  Model NACKs idx 2 always: exactly 3 wr_go at idx 2, fail=1, cmd_idx=2, done=0.
//  Model never pulses wr_ok: fail=1 exactly TIMEOUT cycles after first wr_go.
//  start held high through run: single sequence only; start after DONE reruns, done
//   clears in first cycle.
//  reset_n low during WAIT_OK of idx 4: all outputs to reset values asynchronously.

Source files
------------

// File: rtl/mpu9250_init_seq.sv
// mpu9250_init_seq
//   Command sequencer that sits in front of the I2C byte-write engine. On
//   start it writes a fixed six-entry MPU9250 register table, one register per
//   engine transfer. It waits between writes, retries NACKed writes and bounds
//   every transfer with a timeout. Completion or failure is reported upward.
//
// Ports
//   SDA_CLK      in   clock shared with the write engine
//   reset_n      in   asynchronous active-low reset
//   start        in   run request, sampled in IDLE (level) and in DONE/FAIL (rising edge)
//   wr_busy      in   engine busy, low only while the engine is idle
//   wr_ok        in   engine end-of-transfer pulse
//   wr_ack_err   in   engine NACK flag, valid with wr_ok
//   wr_go        out  one-cycle write request to the engine
//   wr_addr      out  7-bit slave address (DEV_ADDR)
//   wr_reg_addr  out  register address of the current entry
//   wr_data      out  data byte of the current entry
//   busy         out  sequence in progress
//   done         out  sticky, all entries written and ACKed
//   fail         out  sticky, retry limit or timeout reached
//   cmd_idx      out  index of the current or failing entry
module mpu9250_init_seq #(
    parameter logic [6:0]  DEV_ADDR   = 7'h68,
    parameter int unsigned MAX_RETRY  = 3,
    parameter int unsigned GAP_CYCLES = 16,
    parameter int unsigned RESET_GAP  = 2000,
    parameter int unsigned TIMEOUT    = 512
) (
    input  logic       SDA_CLK,
    input  logic       reset_n,
    input  logic       start,
    input  logic       wr_busy,
    input  logic       wr_ok,
    input  logic       wr_ack_err,
    output logic       wr_go,
    output logic [6:0] wr_addr,
    output logic [7:0] wr_reg_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [2:0] cmd_idx
);

    localparam int unsigned CNT_MAX = (RESET_GAP > TIMEOUT) ? RESET_GAP : TIMEOUT;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam int unsigned RW      = $clog2(MAX_RETRY + 1);

    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] RESET_LAST = CW'(RESET_GAP - 1);
    localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);
    localparam logic [2:0]    LAST_IDX   = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT_OK,
        S_WAIT_IDLE,
        S_GAP,
        S_DONE,
        S_FAIL
    } state_t;

    function automatic logic [15:0] table_entry(input logic [2:0] idx);
        logic [15:0] e;
        case (idx)
            3'd0:    e = 16'h6B80;  // PWR_MGMT_1: device reset
            3'd1:    e = 16'h6B01;  // PWR_MGMT_1: PLL clock source
            3'd2:    e = 16'h6C00;  // PWR_MGMT_2: all axes on
            3'd3:    e = 16'h1A03;  // CONFIG: DLPF
            3'd4:    e = 16'h1B18;  // GYRO_CONFIG: +-2000 dps
            3'd5:    e = 16'h1C08;  // ACCEL_CONFIG: +-4 g
            default: e = 16'h0000;
        endcase
        return e;
    endfunction

    state_t         state_q, state_d;
    logic [2:0]     cmd_idx_q, cmd_idx_d;
    logic [RW-1:0]  retry_q, retry_d;
    logic [CW-1:0]  gap_q, gap_d;
    logic [CW-1:0]  timeout_q, timeout_d;
    logic           wr_go_q, wr_go_d;
    logic [7:0]     wr_reg_addr_q, wr_reg_addr_d;
    logic [7:0]     wr_data_q, wr_data_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           fail_q, fail_d;
    logic           start_prev_q, start_prev_d;

    logic [15:0]    entry;
    logic           start_rise;
    logic [CW-1:0]  gap_last;

    always_comb begin
        state_d       = state_q;
        cmd_idx_d     = cmd_idx_q;
        retry_d       = retry_q;
        gap_d         = gap_q;
        timeout_d     = timeout_q;
        wr_go_d       = 1'b0;
        wr_reg_addr_d = wr_reg_addr_q;
        wr_data_d     = wr_data_q;
        busy_d        = busy_q;
        done_d        = done_q;
        fail_d        = fail_q;
        start_prev_d  = start;

        entry      = table_entry(cmd_idx_q);
        // Restart from DONE/FAIL needs a fresh rising edge so that a start
        // held high through a run does not loop the sequence forever.
        start_rise = start & ~start_prev_q;
        // A nonzero retry count means a reissue of the current entry is
        // pending; the long settle gap only follows the ACKed device reset.
        gap_last   = ((cmd_idx_q == 3'd0) && (retry_q == '0)) ? RESET_LAST : GAP_LAST;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_LOAD;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    fail_d    = 1'b0;
                    cmd_idx_d = '0;
                    retry_d   = '0;
                end
            end
            S_LOAD: begin
                wr_reg_addr_d = entry[15:8];
                wr_data_d     = entry[7:0];
                state_d       = S_ISSUE;
            end
            S_ISSUE: begin
                if (!wr_busy) begin
                    wr_go_d   = 1'b1;
                    timeout_d = '0;
                    state_d   = S_WAIT_OK;
                end
            end
            S_WAIT_OK: begin
                timeout_d = timeout_q + CW'(1);
                // wr_ok is tested first so a response in the expiry cycle wins.
                if (wr_ok) begin
                    if (!wr_ack_err) begin
                        retry_d = '0;
                        state_d = S_WAIT_IDLE;
                    end else begin
                        retry_d = retry_q + RW'(1);
                        if (retry_q == RETRY_LAST) begin
                            state_d = S_FAIL;
                            busy_d  = 1'b0;
                            fail_d  = 1'b1;
                        end else begin
                            state_d = S_WAIT_IDLE;
                        end
                    end
                end else if (timeout_q == TO_LAST) begin
                    state_d = S_FAIL;
                    busy_d  = 1'b0;
                    fail_d  = 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                if (!wr_busy) begin
                    gap_d   = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == gap_last) begin
                    if (retry_q != '0) begin
                        state_d = S_ISSUE;
                    end else if (cmd_idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        cmd_idx_d = cmd_idx_q + 3'd1;
                        state_d   = S_LOAD;
                    end
                end else begin
                    gap_d = gap_q + CW'(1);
                end
            end
            S_DONE, S_FAIL: begin
                if (start_rise) begin
                    state_d   = S_LOAD;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    fail_d    = 1'b0;
                    cmd_idx_d = '0;
                    retry_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge SDA_CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            cmd_idx_q     <= '0;
            retry_q       <= '0;
            gap_q         <= '0;
            timeout_q     <= '0;
            wr_go_q       <= 1'b0;
            wr_reg_addr_q <= '0;
            wr_data_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            fail_q        <= 1'b0;
            start_prev_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_idx_q     <= cmd_idx_d;
            retry_q       <= retry_d;
            gap_q         <= gap_d;
            timeout_q     <= timeout_d;
            wr_go_q       <= wr_go_d;
            wr_reg_addr_q <= wr_reg_addr_d;
            wr_data_q     <= wr_data_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            fail_q        <= fail_d;
            start_prev_q  <= start_prev_d;
        end
    end

    assign wr_go       = wr_go_q;
    assign wr_addr     = DEV_ADDR;
    assign wr_reg_addr = wr_reg_addr_q;
    assign wr_data     = wr_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign fail        = fail_q;
    assign cmd_idx     = cmd_idx_q;

endmodule
